// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper move scheduler: executor states, command layout
// and default step counts per quarter turn.
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int CMD_W        = 5;
    localparam int CMD_Q_LSB    = 0;
    localparam int CMD_Q_W      = 3;
    localparam int CMD_HALF_BIT = 3;
    localparam int CMD_DIR_BIT  = 4;

    localparam int STEPS_FULL_DEFAULT = 50;
    localparam int STEPS_HALF_DEFAULT = 100;

    // Field order matches CMD_DIR_BIT / CMD_HALF_BIT / CMD_Q_LSB above
    typedef struct packed {
        logic                dir;
        logic                half;
        logic [CMD_Q_W-1:0]  quarters;
    } cmd_t;

endpackage

// File: rtl/step_move_scheduler_cmd_fifo.sv
// cmd_fifo: small synchronous command FIFO with push, pop, occupancy and flush.
// Flush has priority over a simultaneous push or pop.
module cmd_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_wdata,
    input  logic                   i_pop,
    output logic [W-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_level != (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && (r_level != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_level = r_level;

endmodule

// File: rtl/step_move_scheduler.sv
// step_move_scheduler: round-robin arbitration of two move requesters into a command FIFO,
// and an executor that gates step_tick into counted bursts. Optional macro: SOFT_STOP_EN.
module step_move_scheduler
    import stepper_pkg::*;
#(
    parameter int STEPS_FULL = STEPS_FULL_DEFAULT,
    parameter int STEPS_HALF = STEPS_HALF_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_step_tick,
    input  logic                   i_req_a,
    input  logic [CMD_W-1:0]       i_cmd_a,
    output logic                   o_ack_a,
    input  logic                   i_req_b,
    input  logic [CMD_W-1:0]       i_cmd_b,
    output logic                   o_ack_b,
`ifdef SOFT_STOP_EN
    input  logic                   i_stop,
    output logic                   o_aborted,
`endif
    output logic                   o_step_out,
    output logic                   o_dir_out,
    output logic                   o_half_out,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rej,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int REM_W = $clog2(7 * STEPS_HALF + 1);
    localparam int SC_W  = $clog2(SETTLE_CYC) + 1;

    function automatic logic [REM_W-1:0] move_steps(input cmd_t c);
        logic [REM_W-1:0] per_q;
        per_q = c.half ? REM_W'(STEPS_HALF) : REM_W'(STEPS_FULL);
        return REM_W'(c.quarters) * per_q;
    endfunction

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_rr_b;
    logic             r_acked_a;
    logic             r_acked_b;
    logic             r_dir;
    logic             r_half;
    cmd_t             r_cur;
    logic [REM_W-1:0] r_remaining;
    logic [SC_W-1:0]  r_settle_cnt;

    cmd_t             w_cmd_a;
    cmd_t             w_cmd_b;
    cmd_t             w_gnt_cmd;
    logic [CMD_W-1:0] w_fifo_rdata;
    logic [LVL_W-1:0] w_level;
    logic             w_space;
    logic             w_elig_a;
    logic             w_elig_b;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_rej;
    logic             w_push;
    logic             w_pop;
    logic             w_stop;
    logic             w_active;

`ifdef SOFT_STOP_EN
    assign w_stop = i_stop;
`else
    assign w_stop = 1'b0;
`endif

    assign w_cmd_a = cmd_t'(i_cmd_a);
    assign w_cmd_b = cmd_t'(i_cmd_b);

    // Arbiter: a requester acked last cycle is masked so its req may still be high one cycle
    assign w_space  = (w_level < LVL_W'(DEPTH));
    assign w_elig_a = i_req_a && !r_acked_a && w_space && !i_rst;
    assign w_elig_b = i_req_b && !r_acked_b && w_space && !i_rst;
    assign w_gnt_a  = w_elig_a && (!w_elig_b || !r_rr_b);
    assign w_gnt_b  = w_elig_b && (!w_elig_a || r_rr_b);

    assign w_gnt_cmd = w_gnt_a ? w_cmd_a : w_cmd_b;
    assign w_rej     = (w_gnt_a || w_gnt_b) && (w_gnt_cmd.quarters == '0);
    assign w_push    = (w_gnt_a || w_gnt_b) && !w_rej;

    cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_stop),
        .i_push  (w_push),
        .i_wdata (CMD_W'(w_gnt_cmd)),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_level (w_level)
    );

    assign w_active = (r_state == ST_LOAD) || (r_state == ST_SETTLE) || (r_state == ST_RUN);

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_level != '0) && !w_stop) begin
                    w_pop      = 1'b1;
                    w_state_nx = ST_LOAD;
                end
            end
            ST_LOAD:   w_state_nx = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == '0) w_state_nx = ST_RUN;
            ST_RUN:    if (i_step_tick && (r_remaining == REM_W'(1))) w_state_nx = ST_DONE;
            ST_DONE:   w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
        if (w_stop && w_active) w_state_nx = ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_rr_b    <= 1'b0;
            r_acked_a <= 1'b0;
            r_acked_b <= 1'b0;
            r_dir     <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_acked_a <= w_gnt_a;
            r_acked_b <= w_gnt_b;
            if (w_gnt_a)      r_rr_b <= 1'b1;
            else if (w_gnt_b) r_rr_b <= 1'b0;
            if (r_state == ST_LOAD) begin
                r_dir  <= r_cur.dir;
                r_half <= r_cur.half;
            end
        end
    end

    // Move datapath: popped command, step budget and settle countdown
    always_ff @(posedge i_clk) begin
        if (w_pop) r_cur <= cmd_t'(w_fifo_rdata);
        case (r_state)
            ST_LOAD: begin
                r_remaining  <= move_steps(r_cur);
                r_settle_cnt <= SC_W'(SETTLE_CYC - 1);
            end
            ST_SETTLE: r_settle_cnt <= r_settle_cnt - 1'b1;
            ST_RUN:    if (i_step_tick) r_remaining <= r_remaining - 1'b1;
            default: ;
        endcase
    end

    assign o_ack_a    = w_gnt_a;
    assign o_ack_b    = w_gnt_b;
    assign o_rej      = w_rej;
    assign o_step_out = i_step_tick && (r_state == ST_RUN) && !i_rst && !w_stop;
    assign o_dir_out  = r_dir;
    assign o_half_out = r_half;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_DONE) && !i_rst;
    assign o_level    = w_level;
`ifdef SOFT_STOP_EN
    assign o_aborted  = w_stop && w_active && !i_rst;
`endif

endmodule

// File: tb/tb_step_move_scheduler.sv
// Directed bench for step_move_scheduler: a table of single moves plus hand-written
// sequences for arbitration order, FIFO back-pressure, reset mid-move and soft stop.
module tb_step_move_scheduler;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_step_tick = 1'b0;
    logic       i_req_a = 1'b0;
    logic [4:0] i_cmd_a = '0;
    logic       i_req_b = 1'b0;
    logic [4:0] i_cmd_b = '0;
    logic       o_ack_a, o_ack_b, o_step_out, o_dir_out, o_half_out;
    logic       o_busy, o_done, o_rej;
    logic [2:0] o_level;
`ifdef SOFT_STOP_EN
    logic       i_stop = 1'b0;
    logic       o_aborted;
`endif

    step_move_scheduler dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_step_tick (i_step_tick),
        .i_req_a     (i_req_a),
        .i_cmd_a     (i_cmd_a),
        .o_ack_a     (o_ack_a),
        .i_req_b     (i_req_b),
        .i_cmd_b     (i_cmd_b),
        .o_ack_b     (o_ack_b),
`ifdef SOFT_STOP_EN
        .i_stop      (i_stop),
        .o_aborted   (o_aborted),
`endif
        .o_step_out  (o_step_out),
        .o_dir_out   (o_dir_out),
        .o_half_out  (o_half_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rej       (o_rej),
        .o_level     (o_level)
    );

    always #5 clk = ~clk;

    // Step-rate pulse every second clock
    logic tick_en = 1'b1;
    logic tick_ph = 1'b0;
    always @(posedge clk) begin
        #1;
        tick_ph     = ~tick_ph;
        i_step_tick = tick_en & tick_ph;
    end

    int tot_step = 0, tot_done = 0, tot_rej = 0, tot_abort = 0, max_level = 0;
    int ack_q[$];
    always @(negedge clk) begin
        tot_step += int'(o_step_out);
        tot_done += int'(o_done);
        tot_rej  += int'(o_rej);
`ifdef SOFT_STOP_EN
        tot_abort += int'(o_aborted);
`endif
        if (o_ack_a) ack_q.push_back(0);
        if (o_ack_b) ack_q.push_back(1);
        if (int'(o_level) > max_level) max_level = int'(o_level);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack (or timeout)
    task automatic send(input bit to_b, input logic [4:0] cmd, input int limit,
                        output bit got, output bit rj, output int lvl, output int waited);
        got = 1'b0; rj = 1'b0; lvl = 0; waited = 0;
        if (to_b) begin i_cmd_b = cmd; i_req_b = 1'b1; end
        else      begin i_cmd_a = cmd; i_req_a = 1'b1; end
        for (int k = 0; k < limit && !got; k++) begin
            @(negedge clk);
            if (to_b ? o_ack_b : o_ack_a) begin
                got = 1'b1; rj = o_rej; lvl = int'(o_level); waited = k;
            end
            @(posedge clk); #1;
        end
        if (to_b) i_req_b = 1'b0;
        else      i_req_a = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen, output bit dir);
        seen = 1'b0; dir = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (o_done) begin seen = 1'b1; dir = o_dir_out; end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic [4:0] cmd;
        int         steps;
        int         dir;
        int         half;
        int         rej;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, rj, seen, d, ok, b1, b2;
        int lv, wt, s_step, s_done, s_rej, s_abort, q0;
        int exp_dir[4];

        vecs[0] = '{5'b1_0_001,  50, 1, 0, 0};
        vecs[1] = '{5'b0_1_001, 100, 0, 1, 0};
        vecs[2] = '{5'b1_1_010, 200, 1, 1, 0};
        vecs[3] = '{5'b0_0_011, 150, 0, 0, 0};
        vecs[4] = '{5'b1_0_000,   0, 0, 0, 1};

        // Reset state, with ticks running
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy",  int'(o_busy), 0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_done",  int'(o_done), 0);
        chk("rst_dir_half", int'({o_dir_out, o_half_out}), 0);
        chk("rst_step_cnt", tot_step, 0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        // Table: single moves from A
        for (int i = 0; i < 5; i++) begin
            s_step = tot_step; s_done = tot_done; s_rej = tot_rej;
            send(1'b0, vecs[i].cmd, 20, got, rj, lv, wt);
            chk($sformatf("v%0d_ack", i), int'(got), 1);
            chk($sformatf("v%0d_rej_at_ack", i), int'(rj), vecs[i].rej);
            @(negedge clk); b1 = o_busy; @(posedge clk); #1;
            @(negedge clk); b2 = o_busy; @(posedge clk); #1;
            chk($sformatf("v%0d_busy_ack+1", i), int'(b1), 0);
            chk($sformatf("v%0d_busy_ack+2", i), int'(b2), 1 - vecs[i].rej);
            if (vecs[i].rej == 0) begin
                wait_done(3000, seen, d);
                chk($sformatf("v%0d_done_seen", i), int'(seen), 1);
            end
            repeat (30) @(posedge clk);
            #1;
            chk($sformatf("v%0d_steps", i), tot_step - s_step, vecs[i].steps);
            chk($sformatf("v%0d_dones", i), tot_done - s_done, 1 - vecs[i].rej);
            chk($sformatf("v%0d_rejs", i), tot_rej - s_rej, vecs[i].rej);
            chk($sformatf("v%0d_dir", i), int'(o_dir_out), vecs[i].dir);
            chk($sformatf("v%0d_half", i), int'(o_half_out), vecs[i].half);
            chk($sformatf("v%0d_level", i), int'(o_level), 0);
            chk($sformatf("v%0d_idle", i), int'(o_busy), 0);
        end

        // Both requesters together, twice; last grant was A so B leads
        s_step = tot_step;
        q0 = ack_q.size();
        i_cmd_a = 5'b1_0_001;
        i_cmd_b = 5'b0_0_001;
        for (int r = 0; r < 2; r++) begin
            bit pa, pb;
            pa = 1'b1; pb = 1'b1;
            for (int k = 0; k < 20 && (pa || pb); k++) begin
                i_req_a = pa; i_req_b = pb;
                @(negedge clk);
                if (o_ack_a) pa = 1'b0;
                if (o_ack_b) pb = 1'b0;
                @(posedge clk); #1;
            end
            i_req_a = 1'b0; i_req_b = 1'b0;
        end
        @(posedge clk); #1;
        chk("rr_ack_count", ack_q.size() - q0, 4);
        exp_dir = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            int who;
            who = (ack_q.size() > q0 + i) ? ack_q[q0 + i] : -1;
            chk($sformatf("rr_ack%0d_is_b", i), who, exp_dir[i] == 0 ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            wait_done(1000, seen, d);
            chk($sformatf("rr_done%0d_seen", i), int'(seen), 1);
            chk($sformatf("rr_done%0d_dir", i), int'(d), exp_dir[i]);
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rr_steps", tot_step - s_step, 200);

        // Fill FIFO during a long half-step move; fifth request stalls
        s_step = tot_step;
        send(1'b0, 5'b0_1_111, 20, got, rj, lv, wt);
        chk("fill_long_ack", int'(got), 1);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 5'b1_0_001, 20, got, rj, lv, wt);
            chk($sformatf("fill_b%0d_ack", i), int'(got), 1);
        end
        @(negedge clk);
        chk("fill_level_full", int'(o_level), 4);
        @(posedge clk); #1;
        send(1'b0, 5'b0_0_001, 2000, got, rj, lv, wt);
        chk("fill_5th_ack", int'(got), 1);
        chk("fill_5th_stalled", int'(wt > 100), 1);
        chk("fill_level_at_5th_ack", lv, 3);
        ok = 1'b0;
        for (int k = 0; k < 6000 && !ok; k++) begin
            @(negedge clk);
            if (o_level == 3'd0 && !o_busy) ok = 1'b1;
            @(posedge clk); #1;
        end
        chk("fill_drained", int'(ok), 1);
        chk("fill_steps", tot_step - s_step, 950);
        chk("fill_max_level", max_level, 4);

        // Reset in the middle of a running move with one more queued
        s_step = tot_step; s_done = tot_done;
        send(1'b0, 5'b1_0_011, 20, got, rj, lv, wt);
        send(1'b1, 5'b0_0_001, 20, got, rj, lv, wt);
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(posedge clk); #1;
            if (tot_step - s_step >= 20) ok = 1'b1;
        end
        chk("rstmid_reached_20", int'(ok), 1);
        i_rst = 1'b1;
        s_step = tot_step;
        @(negedge clk);
        chk("rstmid_step_out", int'(o_step_out), 0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", int'(o_busy), 0);
        chk("rstmid_level", int'(o_level), 0);
        repeat (200) @(posedge clk);
        #1;
        chk("rstmid_no_steps", tot_step - s_step, 0);
        chk("rstmid_no_done", tot_done - s_done, 0);

`ifdef SOFT_STOP_EN
        // Soft stop during SETTLE with two commands queued
        s_step = tot_step; s_done = tot_done; s_abort = tot_abort;
        send(1'b0, 5'b1_0_001, 20, got, rj, lv, wt);
        send(1'b1, 5'b0_0_001, 20, got, rj, lv, wt);
        send(1'b1, 5'b0_0_001, 20, got, rj, lv, wt);
        @(negedge clk);
        chk("stop_level_before", int'(o_level), 2);
        @(posedge clk); #1;
        i_stop = 1'b1;
        @(negedge clk);
        chk("stop_aborted", int'(o_aborted), 1);
        @(posedge clk); #1;
        i_stop = 1'b0;
        @(negedge clk);
        chk("stop_level", int'(o_level), 0);
        chk("stop_busy", int'(o_busy), 0);
        repeat (200) @(posedge clk);
        #1;
        chk("stop_steps", tot_step - s_step, 0);
        chk("stop_dones", tot_done - s_done, 0);
        chk("stop_abort_count", tot_abort - s_abort, 1);
`else
        s_abort = tot_abort;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
